sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 DATA_WIDTH, default 8, width of each stored word in bits.
REQ-002 FIFO_DEPTH, default 16, number of storage entries; legal range >= 2, need not be a power of two.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr  input  1  write request, sampled on rising clk.
REQ-006 rd  input  1  read request, sampled on rising clk.
REQ-007 data_in  input  DATA_WIDTH  word to store when a write is accepted.
REQ-008 data_out  output  DATA_WIDTH  registered word from the most recent accepted read.
REQ-009 empty  output  1  high when zero entries are stored.
REQ-010 full  output  1  high when FIFO_DEPTH entries are stored.

Function
REQ-011 Write accepted iff wr=1 and full=0 at the clock edge; data_in is stored at the write pointer, and the write pointer advances.
REQ-012 Read accepted iff rd=1 and empty=0 at the clock edge; the word at the read pointer is loaded into data_out, and the read pointer advances.
REQ-013 Read latency: data_out shows the oldest stored word immediately after the accepting edge, one cycle after rd is sampled.
REQ-014 data_out holds its last value on every edge without an accepted read, including reads attempted while empty.
REQ-015 Write while full (overflow) is dropped silently: storage, pointers, count and data_out stay unchanged.
REQ-016 Read while empty (underflow) is ignored silently: pointers, count and data_out stay unchanged.
REQ-017 Simultaneous wr and rd: each is evaluated independently against the pre-edge flags; if both are accepted, the occupancy count is unchanged.
REQ-018 Simultaneous wr and rd while full: the read is accepted and the write is dropped.
REQ-019 Simultaneous wr and rd while empty: the write is accepted and the read is ignored; the written word is not forwarded to data_out.
REQ-020 Pointers wrap from FIFO_DEPTH-1 to 0.
REQ-021 The occupancy count is clog2(FIFO_DEPTH+1) bits wide.
REQ-022 empty and full are registered or derived from the registered count, are valid right after each edge, and are never high together.
REQ-023 Output order is strictly first-in first-out across any number of wrap-arounds.

Reset
REQ-024 Asserting reset clears the read pointer, write pointer and count to 0, and clears data_out to 0, immediately and regardless of clk.
REQ-025 During reset, empty=1 and full=0.
REQ-026 Storage contents need not be cleared.
REQ-027 Reset asserted mid-operation discards all stored data; the first edge after reset deassertion behaves as operation on an empty FIFO.

Structure
REQ-028 No shared package is required.
REQ-029 The pointer/count width is a localparam computed with $clog2 inside the module.
REQ-030 The storage array is a sub-module, sync_fifo_mem (one synchronous write port, one read port), so it can be mapped to block RAM.
REQ-031 Flags and pointer logic stay in sync_fifo.

Verification (DATA_WIDTH=8, FIFO_DEPTH=4)
REQ-032 Reset, then idle -> empty=1, full=0, data_out=0.
REQ-033 Write 0,1,2,3 on consecutive cycles -> empty=0 and full=1 after the 4th edge.
REQ-034 From full, read 4 consecutive cycles -> data_out=0,1,2,3 after the successive edges; empty=1 and full=0 after the last read.
REQ-035 Refill with 0..3, then write 4 while full -> dropped; the next reads yield 0,1,2,3 with empty=0 until the 4th read, and empty=1 after it.
REQ-036 Read while empty after data_out=3 -> data_out stays 3, empty stays 1.
REQ-037 Two entries stored, wr and rd held for 6 cycles with incrementing data -> count stays 2, order preserved across pointer wrap; assert reset mid-stream -> empty=1 and data_out=0 immediately.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared defaults for the synchronous FIFO slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

   // Default geometry used when the FIFO is instantiated without overrides
   localparam int c_DEFAULT_DATA_WIDTH = 8;
   localparam int c_DEFAULT_FIFO_DEPTH = 16;

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_mem
//  Description : Storage array for sync_fifo. One synchronous write port and
//                one read port; contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Store the incoming word on an accepted write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Read port feeds the registered output stage in the parent
   assign rd_data = r_mem[rd_addr];

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered read data, count-derived
//                empty/full flags and silent overflow/underflow handling.
//                Depth need not be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = c_DEFAULT_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full
);

   // Pointer addresses FIFO_DEPTH entries; count must also represent FIFO_DEPTH
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic [DATA_WIDTH-1:0] r_data_out;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_wr_accept;
   logic                  w_rd_accept;
   logic [c_PTR_W-1:0]    w_wr_ptr_next;
   logic [c_PTR_W-1:0]    w_rd_ptr_next;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // Flags come straight from the registered count, so they can never both be high
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_CNT_FULL);

   // Each request is judged against the pre-edge flags independently
   assign w_wr_accept = wr & ~w_full;
   assign w_rd_accept = rd & ~w_empty;

   // Explicit wrap keeps non-power-of-two depths inside the array
   assign w_wr_ptr_next = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_next = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_W     (c_PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_wr_accept),
      .wr_addr (r_wr_ptr),
      .wr_data (data_in),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   // Pointer, occupancy and output-register update; reset discards everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= w_wr_ptr_next;
         end
         if (w_rd_accept) begin
            r_rd_ptr   <= w_rd_ptr_next;
            r_data_out <= w_rd_data;
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_out = r_data_out;
   assign empty    = w_empty;
   assign full     = w_full;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Directed self-checking bench for sync_fifo (8 bits x 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

   localparam int c_DW    = 8;
   localparam int c_DEPTH = 4;

   logic            clk;
   logic            reset;
   logic            wr;
   logic            rd;
   logic [c_DW-1:0] data_in;
   logic [c_DW-1:0] data_out;
   logic            empty;
   logic            full;

   int n_checks;
   int n_errors;

   sync_fifo #(
      .DATA_WIDTH (c_DW),
      .FIFO_DEPTH (c_DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .rd       (rd),
      .data_in  (data_in),
      .data_out (data_out),
      .empty    (empty),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Apply one set of requests across one rising edge, then settle
   task automatic cycle(input logic w, input logic r, input logic [c_DW-1:0] d);
      wr      = w;
      rd      = r;
      data_in = d;
      @(posedge clk);
      #1;
      wr = 1'b0;
      rd = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic exp_empty, input logic exp_full);
      check({tag, "_empty"}, {31'd0, empty}, {31'd0, exp_empty});
      check({tag, "_full"},  {31'd0, full},  {31'd0, exp_full});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      wr       = 1'b0;
      rd       = 1'b0;
      data_in  = '0;

      // Reset state, then idle
      #2;
      check_flags("in_reset", 1'b1, 1'b0);
      check("in_reset_dout", {24'd0, data_out}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle(1'b0, 1'b0, 8'h00);
      check_flags("idle", 1'b1, 1'b0);
      check("idle_dout", {24'd0, data_out}, 32'd0);

      // Fill with 0..3
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 8'(i));
         check_flags($sformatf("fill%0d", i), 1'b0, (i == 3));
      end

      // Drain, expecting FIFO order
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         check($sformatf("drain%0d_dout", i), {24'd0, data_out}, 32'(i));
         check_flags($sformatf("drain%0d", i), (i == 3), 1'b0);
      end

      // Refill, overflow write is dropped
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 8'(i));
      end
      check_flags("refill", 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 8'h04);
      check_flags("overflow", 1'b0, 1'b1);
      check("overflow_dout", {24'd0, data_out}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         check($sformatf("post_ovf%0d_dout", i), {24'd0, data_out}, 32'(i));
         check_flags($sformatf("post_ovf%0d", i), (i == 3), 1'b0);
      end

      // Underflow read leaves everything alone
      cycle(1'b0, 1'b1, 8'h00);
      check("underflow_dout", {24'd0, data_out}, 32'd3);
      check_flags("underflow", 1'b1, 1'b0);

      // Simultaneous wr/rd while empty: write taken, nothing forwarded
      cycle(1'b1, 1'b1, 8'h80);
      check("wr_rd_empty_dout", {24'd0, data_out}, 32'd3);
      check_flags("wr_rd_empty", 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 8'h00);
      check("wr_rd_empty_read", {24'd0, data_out}, 32'h80);
      check_flags("wr_rd_empty_read", 1'b1, 1'b0);

      // Simultaneous wr/rd while full: read taken, write dropped
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 8'(8'h20 + i));
      end
      cycle(1'b1, 1'b1, 8'h99);
      check("wr_rd_full_dout", {24'd0, data_out}, 32'h20);
      check_flags("wr_rd_full", 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         check($sformatf("wr_rd_full_drain%0d", i), {24'd0, data_out}, 32'(8'h20 + i));
      end
      check_flags("wr_rd_full_drained", 1'b1, 1'b0);

      // Two stored, then streaming wr+rd across pointer wrap
      cycle(1'b1, 1'b0, 8'h10);
      cycle(1'b1, 1'b0, 8'h11);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, 8'(8'h12 + i));
         check($sformatf("stream%0d_dout", i), {24'd0, data_out}, 32'(8'h10 + i));
         check_flags($sformatf("stream%0d", i), 1'b0, 1'b0);
      end

      // Reset mid-stream takes effect without a clock edge
      wr      = 1'b1;
      rd      = 1'b1;
      data_in = 8'h77;
      #2;
      reset = 1'b1;
      #1;
      check_flags("async_reset", 1'b1, 1'b0);
      check("async_reset_dout", {24'd0, data_out}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // First edge after reset behaves as an empty FIFO
      cycle(1'b1, 1'b1, 8'h55);
      check("post_reset_dout", {24'd0, data_out}, 32'd0);
      check_flags("post_reset", 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 8'h00);
      check("post_reset_read", {24'd0, data_out}, 32'h55);
      check_flags("post_reset_read", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sync_fifo
`default_nettype wire
